// File: rtl/display_scan_driver_if.sv
// -----------------------------------------------------------------------------
// display_scan_driver_if
// Bundles the signals between the machine FSM / message encoders and the
// display scan driver.
//   estado      : one-hot machine state {VL,SN,SP,SR,S3,S2,S1,S0}, bit0 = S0
//   seg_data    : flat segment patterns, digit k at [7k+6:7k] (bit 7k+6 = a)
//   blink_en    : blink the whole display while high
//   seg         : segment drive {a..g}, active-high
//   digito      : digit selects (polarity set by the driver parameter)
//   frame_tick  : one-cycle pulse at the start of every frame
//   erro_estado : high while estado is not exactly one-hot
// Modports: master = machine side (drives inputs), slave = the driver.
// -----------------------------------------------------------------------------
interface display_scan_driver_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic [7:0]              estado;
    logic [NUM_DIGITS*7-1:0] seg_data;
    logic                    blink_en;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   digito;
    logic                    frame_tick;
    logic                    erro_estado;

    modport master (
        output estado, seg_data, blink_en,
        input  seg, digito, frame_tick, erro_estado
    );

    modport slave (
        input  estado, seg_data, blink_en,
        output seg, digito, frame_tick, erro_estado
    );
endinterface

// File: rtl/display_scan_driver.sv
// -----------------------------------------------------------------------------
// display_scan_driver
// Multiplexed N-digit seven-segment scan driver. Owns the digit-scan counter,
// blanks the start of every digit slot against ghosting, latches the pattern
// bus only at frame start, supports whole-display blinking and flags an
// invalid (non one-hot) machine state.
// Ports:
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   bus     : display_scan_driver_if.slave (estado, seg_data, blink_en in;
//             seg, digito, frame_tick, erro_estado out)
// All outputs are registered; seg/digito show the scan state of the previous
// cycle, frame_tick is aligned with the cycle where idx = 0 and div = 0.
// -----------------------------------------------------------------------------
module display_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int BLINK_FRAMES   = 32,
    parameter int ACTIVE_LOW_DIG = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    display_scan_driver_if.slave  bus
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(BLINK_FRAMES) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? DIV_W'(BLANK_CYCLES - 1)
                                                                 : {DIV_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (ACTIVE_LOW_DIG != 0) ? {NUM_DIGITS{1'b1}}
                                                                      : {NUM_DIGITS{1'b0}};

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Every slot opens in BLANK unless blanking is disabled altogether.
    localparam scan_state_t ST_START = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

    scan_state_t                  state_r;
    logic                         started_r;
    logic [7:0]                   estado_q_r;
    logic [IDX_W-1:0]             idx_r;
    logic [DIV_W-1:0]             div_r;
    logic [NUM_DIGITS-1:0][6:0]   shadow_r;
    logic [CNT_W-1:0]             frame_cnt_r;
    logic                         blink_phase_r;
    logic [6:0]                   seg_r;
    logic [NUM_DIGITS-1:0]        digito_r;
    logic                         frame_tick_r;
    logic                         erro_r;

    logic                         est_ok_s;
    logic                         restart_s;
    logic                         div_last_s;
    logic                         wrap_s;
    logic                         show_s;
    logic [NUM_DIGITS-1:0]        dig_one_s;
    logic [NUM_DIGITS-1:0]        dig_on_s;

    // Decode restart / wrap conditions and the digit select for this cycle.
    always_comb begin
        est_ok_s   = is_onehot(bus.estado);
        // The first edge after reset release behaves like a restart so that
        // the frame_tick of frame 0 is produced like any other restart.
        restart_s  = !started_r || (est_ok_s && (bus.estado != estado_q_r));
        div_last_s = (div_r == DIV_LAST);
        wrap_s     = div_last_s && (idx_r == IDX_LAST);
        show_s     = (state_r == ST_SHOW) && est_ok_s && !(bus.blink_en && blink_phase_r);
        dig_one_s  = {NUM_DIGITS{1'b0}};
        dig_one_s[idx_r] = 1'b1;
        dig_on_s   = (ACTIVE_LOW_DIG != 0) ? ~dig_one_s : dig_one_s;
    end

    // Scan FSM, counters, shadow patterns, blink phase and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_START;
            started_r     <= 1'b0;
            estado_q_r    <= 8'h00;
            idx_r         <= {IDX_W{1'b0}};
            div_r         <= {DIV_W{1'b0}};
            shadow_r      <= {(NUM_DIGITS*7){1'b0}};
            frame_cnt_r   <= {CNT_W{1'b0}};
            blink_phase_r <= 1'b0;
            seg_r         <= 7'h00;
            digito_r      <= DIG_OFF;
            frame_tick_r  <= 1'b0;
            erro_r        <= 1'b0;
        end else begin
            started_r    <= 1'b1;
            estado_q_r   <= bus.estado;
            erro_r       <= !est_ok_s;
            // Restart and natural wrap land on the same next state, so a
            // coincidence still yields a single tick.
            frame_tick_r <= restart_s || wrap_s;

            if (restart_s) begin
                state_r       <= ST_START;
                idx_r         <= {IDX_W{1'b0}};
                div_r         <= {DIV_W{1'b0}};
                shadow_r      <= bus.seg_data;
                frame_cnt_r   <= {CNT_W{1'b0}};
                blink_phase_r <= 1'b0;
            end else if (div_last_s) begin
                state_r <= ST_START;
                div_r   <= {DIV_W{1'b0}};
                if (wrap_s) begin
                    idx_r    <= {IDX_W{1'b0}};
                    shadow_r <= bus.seg_data;
                    if (frame_cnt_r == CNT_LAST) begin
                        frame_cnt_r   <= {CNT_W{1'b0}};
                        blink_phase_r <= ~blink_phase_r;
                    end else begin
                        frame_cnt_r   <= frame_cnt_r + CNT_W'(1);
                    end
                end else begin
                    idx_r <= idx_r + IDX_W'(1);
                end
            end else begin
                div_r <= div_r + DIV_W'(1);
                case (state_r)
                    ST_BLANK: begin
                        if (div_r == BLANK_LAST) begin
                            state_r <= ST_SHOW;
                        end else begin
                            state_r <= ST_BLANK;
                        end
                    end
                    ST_SHOW: state_r <= ST_SHOW;
                    default: state_r <= ST_START;
                endcase
            end

            if (show_s) begin
                seg_r    <= shadow_r[idx_r];
                digito_r <= dig_on_s;
            end else begin
                seg_r    <= 7'h00;
                digito_r <= DIG_OFF;
            end
        end
    end

    assign bus.seg         = seg_r;
    assign bus.digito      = digito_r;
    assign bus.frame_tick  = frame_tick_r;
    assign bus.erro_estado = erro_r;
endmodule

// File: tb/tb_display_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_display_scan_driver
// Scoreboard bench for display_scan_driver (NUM_DIGITS=4, SCAN_DIV=8,
// BLANK_CYCLES=2, BLINK_FRAMES=2, ACTIVE_LOW_DIG=1). The stimulus process
// queues hand-computed expected outputs tagged with the cycle number counted
// from reset release (cycle 0 = first cycle after the first clock edge); a
// separate monitor pops and compares them at the falling edge. Entries tagged
// IMM are compared immediately when the stimulus fires probe_ev (used for the
// asynchronous reset behaviour).
// -----------------------------------------------------------------------------
module tb_display_scan_driver;
    localparam int ND  = 4;
    localparam int IMM = -2;

    localparam logic [27:0] SEG_A    = {7'h7F, 7'h7E, 7'h4F, 7'h4E};
    localparam logic [27:0] SEG_ONES = {7'h01, 7'h01, 7'h01, 7'h01};
    localparam logic [27:0] SEG_B    = {7'h30, 7'h6D, 7'h79, 7'h33};

    typedef struct {
        int         cyc;
        logic [6:0] seg;
        logic [3:0] dig;
        logic       tick;
        logic       err;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = -1;
    int   checks  = 0;
    int   errors  = 0;
    bit   end_req = 1'b0;
    exp_t sb[$];
    exp_t cur;
    event probe_ev;

    display_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    display_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV(8), .BLANK_CYCLES(2),
        .BLINK_FRAMES(2), .ACTIVE_LOW_DIG(1)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Cycle number relative to reset release.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= -1;
        else          cyc <= cyc + 1;
    end

    // Monitor: pop every expectation that is due and compare with the outputs.
    always @(negedge clock or probe_ev) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            checks = checks + 1;
            if ((cur.cyc != IMM && cur.cyc != cyc) || bus.seg !== cur.seg ||
                bus.digito !== cur.dig || bus.frame_tick !== cur.tick ||
                bus.erro_estado !== cur.err) begin
                errors = errors + 1;
                $display("FAIL out_c%0d at cyc %0d: got seg=%h dig=%h tick=%b err=%b, want seg=%h dig=%h tick=%b err=%b",
                         cur.cyc, cyc, bus.seg, bus.digito, bus.frame_tick, bus.erro_estado,
                         cur.seg, cur.dig, cur.tick, cur.err);
            end
        end
        if (end_req) begin
            checks = checks + 1;
            if (sb.size() != 0) begin
                errors = errors + 1;
                $display("FAIL sb_drain: got %0d unconsumed expectations, want 0", sb.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic exp_at(input int c, input logic [6:0] s, input logic [3:0] d,
                          input logic t, input logic e);
        exp_t x;
        x.cyc = c; x.seg = s; x.dig = d; x.tick = t; x.err = e;
        sb.push_back(x);
    endtask

    task automatic probe(input logic [6:0] s, input logic [3:0] d, input logic t, input logic e);
        exp_at(IMM, s, d, t, e);
        -> probe_ev;
        #0;
    endtask

    // Advance to #1 after the edge that starts cycle n (bounded).
    task automatic goto(input int n);
        int guard = 0;
        while (cyc < n && guard < 2000) begin
            @(posedge clock);
            #1;
            guard++;
        end
    endtask

    task automatic restart_run();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.estado   = 8'h10;
        bus.seg_data = SEG_A;
        bus.blink_en = 1'b0;
        #15;
        probe(7'h00, 4'hF, 1'b0, 1'b0);            // reset state
        #1;

        // Run 1: basic scan, frame-synchronous pattern update.
        restart_run();
        exp_at(0,  7'h00, 4'hF, 1'b1, 1'b0);
        exp_at(1,  7'h00, 4'hF, 1'b0, 1'b0);
        exp_at(2,  7'h00, 4'hF, 1'b0, 1'b0);
        exp_at(3,  7'h4E, 4'hE, 1'b0, 1'b0);
        exp_at(8,  7'h4E, 4'hE, 1'b0, 1'b0);
        exp_at(9,  7'h00, 4'hF, 1'b0, 1'b0);
        exp_at(11, 7'h4F, 4'hD, 1'b0, 1'b0);
        exp_at(19, 7'h7E, 4'hB, 1'b0, 1'b0);
        exp_at(27, 7'h7F, 4'h7, 1'b0, 1'b0);
        exp_at(32, 7'h7F, 4'h7, 1'b1, 1'b0);
        exp_at(33, 7'h00, 4'hF, 1'b0, 1'b0);
        exp_at(35, 7'h01, 4'hE, 1'b0, 1'b0);
        exp_at(43, 7'h01, 4'hD, 1'b0, 1'b0);
        exp_at(64, 7'h01, 4'h7, 1'b1, 1'b0);
        goto(12);
        bus.seg_data = SEG_ONES;
        goto(66);

        // Run 2: restart on state change, then invalid state window.
        bus.seg_data = SEG_A;
        restart_run();
        exp_at(0,   7'h00, 4'hF, 1'b1, 1'b0);
        exp_at(12,  7'h4F, 4'hD, 1'b0, 1'b0);
        exp_at(13,  7'h4F, 4'hD, 1'b0, 1'b0);
        exp_at(14,  7'h4F, 4'hD, 1'b1, 1'b0);
        exp_at(15,  7'h00, 4'hF, 1'b0, 1'b0);
        exp_at(16,  7'h00, 4'hF, 1'b0, 1'b0);
        exp_at(17,  7'h33, 4'hE, 1'b0, 1'b0);
        exp_at(22,  7'h33, 4'hE, 1'b0, 1'b0);
        exp_at(23,  7'h00, 4'hF, 1'b0, 1'b0);
        exp_at(25,  7'h79, 4'hD, 1'b0, 1'b0);
        exp_at(32,  7'h00, 4'hF, 1'b0, 1'b0);
        exp_at(45,  7'h30, 4'h7, 1'b0, 1'b0);
        exp_at(46,  7'h30, 4'h7, 1'b1, 1'b0);
        exp_at(50,  7'h33, 4'hE, 1'b0, 1'b0);
        exp_at(51,  7'h00, 4'hF, 1'b0, 1'b1);
        exp_at(57,  7'h00, 4'hF, 1'b0, 1'b1);
        exp_at(70,  7'h00, 4'hF, 1'b0, 1'b1);
        exp_at(71,  7'h00, 4'hF, 1'b1, 1'b0);
        exp_at(72,  7'h00, 4'hF, 1'b0, 1'b0);
        exp_at(74,  7'h33, 4'hE, 1'b0, 1'b0);
        exp_at(78,  7'h33, 4'hE, 1'b0, 1'b0);
        exp_at(103, 7'h30, 4'h7, 1'b1, 1'b0);
        goto(10);
        bus.seg_data = SEG_B;
        goto(13);
        bus.estado = 8'h01;
        goto(50);
        bus.estado = 8'h11;
        goto(70);
        bus.estado = 8'h01;
        goto(105);

        // Run 3: blinking, with blink_en dropped during a blanked frame.
        bus.estado   = 8'h10;
        bus.seg_data = SEG_A;
        bus.blink_en = 1'b1;
        restart_run();
        exp_at(0,   7'h00, 4'hF, 1'b1, 1'b0);
        exp_at(3,   7'h4E, 4'hE, 1'b0, 1'b0);
        exp_at(35,  7'h4E, 4'hE, 1'b0, 1'b0);
        exp_at(64,  7'h7F, 4'h7, 1'b1, 1'b0);
        exp_at(65,  7'h00, 4'hF, 1'b0, 1'b0);
        exp_at(67,  7'h00, 4'hF, 1'b0, 1'b0);
        exp_at(96,  7'h00, 4'hF, 1'b1, 1'b0);
        exp_at(99,  7'h00, 4'hF, 1'b0, 1'b0);
        exp_at(100, 7'h00, 4'hF, 1'b0, 1'b0);
        exp_at(101, 7'h4E, 4'hE, 1'b0, 1'b0);
        exp_at(128, 7'h7F, 4'h7, 1'b1, 1'b0);
        exp_at(131, 7'h4E, 4'hE, 1'b0, 1'b0);
        goto(100);
        bus.blink_en = 1'b0;
        goto(133);

        // Run 4: asynchronous reset in the middle of digit 2.
        restart_run();
        goto(20);
        probe(7'h7E, 4'hB, 1'b0, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        probe(7'h00, 4'hF, 1'b0, 1'b0);
        #1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        reset_n = 1'b1;
        exp_at(0,  7'h00, 4'hF, 1'b1, 1'b0);
        exp_at(3,  7'h4E, 4'hE, 1'b0, 1'b0);
        exp_at(11, 7'h4F, 4'hD, 1'b0, 1'b0);
        goto(13);

        end_req = 1'b1;
        -> probe_ev;
        #100;
        $display("FAIL end: got no summary from monitor, want summary");
        $fatal(1, "monitor did not finish");
    end
endmodule
